// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands plus carry-in, LSB first,
// one bit per clock through a single full-adder slice and a carry flop.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_sh_q, b_sh_q;
  // The bit shifted out of the result register on the final edge is never
  // needed, so only the upper WIDTH-1 result bits are kept between edges.
  logic [WIDTH-2:0] s_sh_q;
  logic             c_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic             bit_s;
  logic             carry_s;
  logic             last_s;
  logic [WIDTH-1:0] s_next;

  assign bit_s   = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
  assign carry_s = (a_sh_q[0] & b_sh_q[0]) | (c_q & (a_sh_q[0] ^ b_sh_q[0]));
  assign s_next  = {bit_s, s_sh_q};
  assign last_s  = (cnt_q == CNT_W'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others, matching real hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ADD;
      ADD:     if (last_s) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ADD);
    done = (state_q == DONE);
  end

  // NOTE: every datapath register is asynchronously reset so an abort mid-ADD
  // leaves no partial result visible and the block restarts from a known state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q <= '0;
      b_sh_q <= '0;
      s_sh_q <= '0;
      c_q    <= 1'b0;
      cnt_q  <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sh_q <= a;
            b_sh_q <= b;
            c_q    <= cin;
            cnt_q  <= '0;
          end
        end
        ADD: begin
          a_sh_q <= a_sh_q >> 1;
          b_sh_q <= b_sh_q >> 1;
          s_sh_q <= s_next[WIDTH-1:1];
          c_q    <= carry_s;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (last_s) begin
            sum_q  <= s_next;
            cout_q <= carry_s;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
